// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO input sampler: default parameter values,
// pin-index width, the wait-FSM state encoding and the per-SM pin-view
// rotation helper.
// ---------------------------------------------------------------------------
package gpio_pkg;

  localparam int NUM_SM_DEF      = 4;   // state machines served
  localparam int SYNC_STAGES_DEF = 2;   // synchronizer depth, legal 2..3
  localparam int PIN_IDX_W       = 5;   // bits needed to name one of 32 pins
  localparam int NUM_PINS        = 32;

  typedef logic [PIN_IDX_W-1:0] pin_idx_t;

  typedef enum logic [1:0] {
    WAIT_IDLE  = 2'd0,
    WAIT_ARMED = 2'd1,
    WAIT_HOLD  = 2'd2
  } wait_state_e;

  // Bit i of the view is pin (i + base) mod 32; the 5-bit add wraps for free.
  function automatic logic [NUM_PINS-1:0] rotate_view(
    input logic [NUM_PINS-1:0] pins,
    input pin_idx_t            base
  );
    logic [NUM_PINS-1:0] view;
    view = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      view[i] = pins[pin_idx_t'(i) + base];
    end
    return view;
  endfunction

endpackage

// File: rtl/gpio_wait_unit.sv
// ---------------------------------------------------------------------------
// gpio_wait_unit
// One state machine's "wait for pin level" FSM.
//   clk, reset    : clock, synchronous active-high reset
//   pins_synced   : synchronized pin levels (32)
//   req           : wait request level, held high until the SM is done
//   wait_pin      : absolute pin index, captured on IDLE->ARMED
//   wait_pol      : required level, captured on IDLE->ARMED
//   done          : registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module gpio_wait_unit
  import gpio_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_PINS-1:0] pins_synced,
  input  logic                req,
  input  pin_idx_t            wait_pin,
  input  logic                wait_pol,
  output logic                done
);

  wait_state_e state_q, state_d;
  pin_idx_t    pin_q, pin_d;
  logic        pol_q, pol_d;
  logic        done_q, done_d;
  logic        match;

  // Compared against the captured selection only, so later changes on
  // wait_pin/wait_pol cannot disturb a wait in progress.
  assign match = (pins_synced[pin_q] == pol_q);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    state_d = state_q;
    pin_d   = pin_q;
    pol_d   = pol_q;
    done_d  = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (req) begin
          state_d = WAIT_ARMED;
          pin_d   = wait_pin;
          pol_d   = wait_pol;
        end
      end
      WAIT_ARMED: begin
        // A dropped request abandons the wait even if the pin matches now.
        if (!req) begin
          state_d = WAIT_IDLE;
        end else if (match) begin
          state_d = WAIT_HOLD;
          done_d  = 1'b1;
        end
      end
      WAIT_HOLD: begin
        // Stay here while req is held so only one done is produced.
        if (!req) state_d = WAIT_IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its _d value from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_IDLE;
      pin_q   <= '0;
      pol_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      pol_q   <= pol_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/gpio_input_sampler.sv
// ---------------------------------------------------------------------------
// gpio_input_sampler
// Synchronizes 32 asynchronous pad inputs, offers per-SM rotated pin views,
// per-pin edge pulses and per-SM pin-level wait units.
//   clk, reset       : clock, synchronous active-high reset
//   in_gpioPins      : raw pad levels (32)
//   in_syncBypass    : per pin, 1 = single-flop path
//   in_smInBase      : packed 5-bit IN base per SM
//   in_smWaitReq     : per-SM wait request level
//   in_smWaitPin     : packed 5-bit wait pin per SM
//   in_smWaitPol     : per-SM required level
//   out_pinsSynced   : synchronized levels / CPU readback (32)
//   out_smPinsView   : packed 32-bit rotated view per SM
//   out_smWaitDone   : per-SM one-cycle done pulse
//   out_risingEdge   : per-pin rising-edge pulse (32)
//   out_fallingEdge  : per-pin falling-edge pulse (32)
// ---------------------------------------------------------------------------
module gpio_input_sampler
  import gpio_pkg::*;
#(
  parameter int NUM_SM      = NUM_SM_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF   // 2..3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PINS-1:0]            in_gpioPins,
  input  logic [NUM_PINS-1:0]            in_syncBypass,
  input  logic [PIN_IDX_W*NUM_SM-1:0]    in_smInBase,
  input  logic [NUM_SM-1:0]              in_smWaitReq,
  input  logic [PIN_IDX_W*NUM_SM-1:0]    in_smWaitPin,
  input  logic [NUM_SM-1:0]              in_smWaitPol,
  output logic [NUM_PINS-1:0]            out_pinsSynced,
  output logic [NUM_PINS*NUM_SM-1:0]     out_smPinsView,
  output logic [NUM_SM-1:0]              out_smWaitDone,
  output logic [NUM_PINS-1:0]            out_risingEdge,
  output logic [NUM_PINS-1:0]            out_fallingEdge
);

  localparam int                 PRIME_W    = 3;
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
  logic [NUM_PINS-1:0]                  pins_synced;
  logic [NUM_PINS-1:0]                  prev_q, prev_d;
  logic [PRIME_W-1:0]                   prime_q, prime_d;
  logic                                 primed;

  // Bypass only selects the tap; the chain keeps shifting, so switching
  // paths is immediate and needs no flush.
  assign pins_synced = (sync_q[0] & in_syncBypass)
                     | (sync_q[SYNC_STAGES-1] & ~in_syncBypass);

  // Edges are meaningless until the chain and prev register hold real
  // samples; this takes SYNC_STAGES+1 edges after reset release.
  assign primed = (prime_q == PRIME_DONE);

  always_comb begin
    sync_d[0] = in_gpioPins;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d  = pins_synced;
    prime_d = primed ? prime_q : prime_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the synchronizer array is reset on purpose: it feeds visible
      // outputs and must read 0 during reset, unlike a RAM-style storage array.
      sync_q  <= '0;
      prev_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
    end
  end

  assign out_pinsSynced  = pins_synced;
  assign out_risingEdge  = primed ? (pins_synced & ~prev_q) : '0;
  assign out_fallingEdge = primed ? (~pins_synced & prev_q) : '0;

  for (genvar n = 0; n < NUM_SM; n++) begin : g_sm
    assign out_smPinsView[NUM_PINS*n +: NUM_PINS] =
      rotate_view(pins_synced, in_smInBase[PIN_IDX_W*n +: PIN_IDX_W]);

    gpio_wait_unit u_wait (
      .clk         (clk),
      .reset       (reset),
      .pins_synced (pins_synced),
      .req         (in_smWaitReq[n]),
      .wait_pin    (in_smWaitPin[PIN_IDX_W*n +: PIN_IDX_W]),
      .wait_pol    (in_smWaitPol[n]),
      .done        (out_smWaitDone[n])
    );
  end

endmodule
